serpent_xts_tweak_gen: RTL and testbench
========================================

# serpent_xts_tweak_gen

XTS tweak generator for the Serpent-XTS datapath. It accepts a 128-bit data-unit (sector) number and drives it into the Serpent encrypt core, which holds key2. It captures the encrypted result as the initial tweak T0, then streams BLOCKS_PER_SECTOR per-block tweaks Tj = T0·α^j over GF(2^128) to the whitening stage on a valid/ready handshake. It sits both upstream of the encrypt core (drives its data and enable inputs) and downstream of it (consumes its output).

## Interface
- BLOCKS_PER_SECTOR, 32, tweaks per data unit; legal range 1..65536.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rstn  in  1  reset; asynchronous assert, active-low.
- i_sector_valid  in  1  data-unit number request.
- i_sector  in  128  data-unit number, already in IEEE 1619 byte order.
- o_sector_ready  out  1  high only in IDLE; reset value 1.
- o_enc_enable  out  1  to core i_enable_encrypt; reset value 0.
- o_enc_data  out  128  to core i_data; reset value 0.
- i_enc_data  in  128  from core o_data.
- i_enc_valid  in  1  from core o_data_valid.
- o_tweak  out  128  current tweak Tj; reset value 0.
- o_tweak_valid  out  1  tweak valid; reset value 0.
- o_tweak_last  out  1  Tj is the last tweak of the data unit (j = BLOCKS_PER_SECTOR-1); reset value 0.
- i_tweak_ready  in  1  downstream accepts the tweak.

## Operation
- FSM states: IDLE, ENC, STREAM. Reset puts the FSM in IDLE.
- **IDLE:**
  - o_sector_ready=1.
  - On i_sector_valid: register i_sector into o_enc_data, clear the block counter, go to ENC.
- **ENC:**
  - o_enc_enable=1 and o_enc_data stable.
  - i_enc_valid is ignored in the first ENC cycle, which guards against a stale valid from the previous request.
  - On the first later cycle with i_enc_valid=1: o_tweak ← i_enc_data, go to STREAM.
  - There is no timeout; the block waits indefinitely.
- **STREAM:**
  - o_tweak_valid=1.
  - o_tweak_last = (count == BLOCKS_PER_SECTOR-1).
  - On a handshake (valid & ready):
    - If last: go to IDLE.
    - Otherwise: o_tweak ← mul_alpha(o_tweak) and count+1.
- **Byte order:**
  - Byte k = bus[127-8k -: 8].
  - Integer form X = {byte15..byte0}.
- **mul_alpha:** X' = (X<<1) ^ (X[127] ? 128'h87 : 0), computed on the integer form and mapped back to bus order.
- Counter width: clog2(BLOCKS_PER_SECTOR)+1 bits; it never wraps.
- With BLOCKS_PER_SECTOR=1, T0 is presented with o_tweak_last=1.
- i_sector_valid outside IDLE is ignored and not queued.

## Timing
- Sector accepted at edge N: ENC and o_enc_enable=1 from N+1.
- i_enc_valid sampled high at edge M (M ≥ N+2): o_enc_enable=0 and o_tweak_valid=1 from M+1.
- Throughput is one tweak per cycle while i_tweak_ready=1.
- o_tweak and o_tweak_last are held stable while valid && !ready.
- Last handshake at edge L: o_tweak_valid=0 and o_sector_ready=1 from L+1. The next request is accepted at L+1 at the earliest.
- A reset assertion in any state clears all outputs to their reset values immediately, with no waiting on an edge. The first edge after deassertion is a normal IDLE cycle.

## Structure
- Package serpent_xts_pkg:
  - state enum (IDLE/ENC/STREAM)
  - XTS_POLY = 8'h87
  - BLOCK_W = 128
  - byte-swap function for bus↔integer conversion
- Sub-module xts_mul_alpha: purely combinational, 128 in / 128 out, bus byte order. It is reused by the later decrypt-side tweak path.

## Test plan
- **Basic multiply:** i_sector=0, core model returns 128'h0100…00; ready held high. Expect T0=128'h0100…00, T1=128'h0200…00, T2=128'h0400…00, and 32 tweaks total with o_tweak_last only on the 32nd.
- **Cross-byte carry and reduction:**
  - Case 1: T0=128'h8000…00 must give T1=128'h0001_00…00.
  - Case 2: T0=128'h00…0080 (byte15=0x80) must give T1=128'h8700…00.
- **Backpressure:** random i_tweak_ready at 30% duty. Expect o_tweak stable while stalled, the sequence identical to the no-stall run, and no dropped or duplicated tweaks.
- **Handshake with core:**
  - Core model asserts i_enc_valid 40 cycles after enable and holds it high.
  - Expect o_enc_enable to fall exactly one cycle after the first valid sample.
  - Expect a stale i_enc_valid=1 in the first ENC cycle of a back-to-back request to be ignored.
- **Edge parameter and blocked requests:** BLOCKS_PER_SECTOR=1 gives a single tweak with last=1, then IDLE. i_sector_valid pulsed during STREAM is ignored.
- **Reset mid-stream:** assert i_rstn=0 after the 5th tweak. Expect o_tweak_valid=0, o_enc_enable=0, o_sector_ready=1 immediately; after release a new sector restarts from T0.

Source files
------------

// File: rtl/serpent_xts_tweak_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serpent_xts_pkg
//  Brief    : Shared types, constants and byte-order helper for the
//             Serpent-XTS tweak path.
//  Revision : 1.0  initial release
// ============================================================================
package serpent_xts_pkg;

    localparam int         BLOCK_W  = 128;
    localparam logic [7:0] XTS_POLY = 8'h87;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENC    = 2'd1,
        ST_STREAM = 2'd2
    } state_e;

    // Bus byte k lives at bus[127-8k -: 8]; the integer form places byte k at
    // bits [8k +: 8]. The mapping is its own inverse.
    function automatic logic [BLOCK_W-1:0] byte_swap(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        y = '0;
        for (int k = 0; k < BLOCK_W/8; k++) begin
            y[8*k +: 8] = x[BLOCK_W-1-8*k -: 8];
        end
        return y;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serpent_xts_tweak_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : serpent_xts_tweak_gen_if
//  Brief    : Sector request, encrypt-core and tweak-stream signals of the
//             XTS tweak generator. Names are from the generator's viewpoint.
//  Revision : 1.0  initial release
// ============================================================================
interface serpent_xts_tweak_gen_if;
    import serpent_xts_pkg::*;

    logic               i_sector_valid;
    logic [BLOCK_W-1:0] i_sector;
    logic               o_sector_ready;
    logic               o_enc_enable;
    logic [BLOCK_W-1:0] o_enc_data;
    logic [BLOCK_W-1:0] i_enc_data;
    logic               i_enc_valid;
    logic [BLOCK_W-1:0] o_tweak;
    logic               o_tweak_valid;
    logic               o_tweak_last;
    logic               i_tweak_ready;

    // Tweak generator side
    modport master (
        input  i_sector_valid, i_sector, i_enc_data, i_enc_valid, i_tweak_ready,
        output o_sector_ready, o_enc_enable, o_enc_data,
               o_tweak, o_tweak_valid, o_tweak_last
    );

    // Requester / core / whitening side
    modport slave (
        output i_sector_valid, i_sector, i_enc_data, i_enc_valid, i_tweak_ready,
        input  o_sector_ready, o_enc_enable, o_enc_data,
               o_tweak, o_tweak_valid, o_tweak_last
    );

endinterface
`default_nettype wire

// File: rtl/serpent_xts_tweak_gen_mul_alpha.sv
`default_nettype none
// ============================================================================
//  Module   : xts_mul_alpha
//  Brief    : Multiply a bus-ordered 128-bit tweak by alpha in GF(2^128)
//             (x^128 + x^7 + x^2 + x + 1). Purely combinational.
//  Revision : 1.0  initial release
// ============================================================================
module xts_mul_alpha
    import serpent_xts_pkg::*;
(
    input  wire logic [BLOCK_W-1:0] i_tweak,
    output logic      [BLOCK_W-1:0] o_tweak
);

    logic [BLOCK_W-1:0] w_int;
    logic [BLOCK_W-1:0] w_mul;

    // Shift in integer form, fold the carried-out bit back with the polynomial
    assign w_int   = byte_swap(i_tweak);
    assign w_mul   = {w_int[BLOCK_W-2:0], 1'b0}
                   ^ {{(BLOCK_W-8){1'b0}}, (w_int[BLOCK_W-1] ? XTS_POLY : 8'h00)};
    assign o_tweak = byte_swap(w_mul);

endmodule
`default_nettype wire

// File: rtl/serpent_xts_tweak_gen.sv
`default_nettype none
// ============================================================================
//  Module   : serpent_xts_tweak_gen
//  Brief    : Encrypts a data-unit number through the Serpent core (key2) to
//             obtain T0, then streams T0*alpha^j for j = 0..BLOCKS_PER_SECTOR-1.
//  Revision : 1.0  initial release
// ============================================================================
module serpent_xts_tweak_gen
    import serpent_xts_pkg::*;
#(
    parameter int BLOCKS_PER_SECTOR = 32
)
(
    input  wire logic              i_clk,
    input  wire logic              i_rstn,
    serpent_xts_tweak_gen_if.master xts
);

    localparam int                 c_CNT_W    = $clog2(BLOCKS_PER_SECTOR) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(BLOCKS_PER_SECTOR - 1);

    localparam logic [1:0] c_IDLE   = ST_IDLE;
    localparam logic [1:0] c_ENC    = ST_ENC;
    localparam logic [1:0] c_STREAM = ST_STREAM;

    logic [1:0]         r_state;
    logic               r_enc_first;
    logic [BLOCK_W-1:0] r_enc_data;
    logic [BLOCK_W-1:0] r_tweak;
    logic [c_CNT_W-1:0] r_cnt;
    logic [BLOCK_W-1:0] w_tweak_next;
    logic               w_last;

    xts_mul_alpha u_mul_alpha (
        .i_tweak (r_tweak),
        .o_tweak (w_tweak_next)
    );

    assign w_last = (r_cnt == c_LAST_CNT);

    // Request capture, core wait (first ENC cycle masks stale valids) and tweak stepping
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= c_IDLE;
            r_enc_first <= 1'b0;
            r_enc_data  <= '0;
            r_tweak     <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (xts.i_sector_valid) begin
                        r_enc_data  <= xts.i_sector;
                        r_cnt       <= '0;
                        r_enc_first <= 1'b1;
                        r_state     <= c_ENC;
                    end
                end
                c_ENC: begin
                    r_enc_first <= 1'b0;
                    if (!r_enc_first && xts.i_enc_valid) begin
                        r_tweak <= xts.i_enc_data;
                        r_state <= c_STREAM;
                    end
                end
                c_STREAM: begin
                    if (xts.i_tweak_ready) begin
                        if (w_last) begin
                            r_state <= c_IDLE;
                        end else begin
                            r_tweak <= w_tweak_next;
                            r_cnt   <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign xts.o_sector_ready = (r_state == c_IDLE);
    assign xts.o_enc_enable   = (r_state == c_ENC);
    assign xts.o_enc_data     = r_enc_data;
    assign xts.o_tweak        = r_tweak;
    assign xts.o_tweak_valid  = (r_state == c_STREAM);
    assign xts.o_tweak_last   = (r_state == c_STREAM) && w_last;

endmodule
`default_nettype wire

// File: tb/tb_serpent_xts_tweak_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serpent_xts_tweak_gen
//  Brief    : Directed self-checking bench for the XTS tweak generator, one
//             instance with 32 tweaks per sector and one with a single tweak.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serpent_xts_tweak_gen;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    serpent_xts_tweak_gen_if ifc ();
    serpent_xts_tweak_gen_if ifc1 ();

    serpent_xts_tweak_gen #(.BLOCKS_PER_SECTOR(32)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .xts    (ifc)
    );

    serpent_xts_tweak_gen #(.BLOCKS_PER_SECTOR(1)) dut1 (
        .i_clk  (clk),
        .i_rstn (rstn),
        .xts    (ifc1)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference alpha multiply written byte by byte on the bus order
    function automatic logic [127:0] model_alpha(input logic [127:0] t);
        logic [7:0]   b  [16];
        logic [7:0]   nb [16];
        logic [127:0] r;
        for (int k = 0; k < 16; k++) b[k] = t[127-8*k -: 8];
        for (int k = 1; k < 16; k++) nb[k] = {b[k][6:0], b[k-1][7]};
        nb[0] = {b[0][6:0], 1'b0} ^ (b[15][7] ? 8'h87 : 8'h00);
        r = '0;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = nb[k];
        return r;
    endfunction

    logic [127:0] exp_t;
    logic [127:0] exp_seq [32];
    int           j;
    int           cyc;
    logic         was_ready;

    initial begin
        ifc.i_sector_valid  = 1'b0;
        ifc.i_sector        = '0;
        ifc.i_enc_data      = '0;
        ifc.i_enc_valid     = 1'b0;
        ifc.i_tweak_ready   = 1'b0;
        ifc1.i_sector_valid = 1'b0;
        ifc1.i_sector       = '0;
        ifc1.i_enc_data     = '0;
        ifc1.i_enc_valid    = 1'b0;
        ifc1.i_tweak_ready  = 1'b0;

        // ---- reset state
        #2;
        chk("rst_sector_ready", ifc.o_sector_ready, 1);
        chk("rst_enc_enable",   ifc.o_enc_enable,   0);
        chk("rst_enc_data",     ifc.o_enc_data,     0);
        chk("rst_tweak",        ifc.o_tweak,        0);
        chk("rst_tweak_valid",  ifc.o_tweak_valid,  0);
        chk("rst_tweak_last",   ifc.o_tweak_last,   0);
        @(negedge clk);
        rstn = 1'b1;
        step();
        chk("idle_after_rst", ifc.o_sector_ready, 1);

        // ---- basic multiply, core answers 40 cycles after enable
        ifc.i_sector       = '0;
        ifc.i_sector_valid = 1'b1;
        step();
        ifc.i_sector_valid = 1'b0;
        chk("enc_enable_rise", ifc.o_enc_enable, 1);
        chk("sector_ready_low", ifc.o_sector_ready, 0);
        repeat (40) step();
        chk("enc_wait_enable", ifc.o_enc_enable, 1);
        chk("enc_wait_novalid", ifc.o_tweak_valid, 0);
        ifc.i_enc_data  = 128'h01 << 120;
        ifc.i_enc_valid = 1'b1;
        step();
        chk("enc_enable_fall", ifc.o_enc_enable, 0);
        chk("stream_valid", ifc.o_tweak_valid, 1);
        ifc.i_tweak_ready = 1'b1;
        exp_t = 128'h01 << 120;
        for (int k = 0; k < 32; k++) begin
            chk("basic_valid", ifc.o_tweak_valid, 1);
            chk("basic_tweak", ifc.o_tweak, exp_t);
            chk("basic_last", ifc.o_tweak_last, (k == 31));
            if (k == 1) chk("basic_T1", ifc.o_tweak, 128'h02 << 120);
            if (k == 2) chk("basic_T2", ifc.o_tweak, 128'h04 << 120);
            step();
            exp_t = model_alpha(exp_t);
        end
        chk("basic_done_valid", ifc.o_tweak_valid, 0);
        chk("basic_done_ready", ifc.o_sector_ready, 1);

        // ---- back-to-back request with stale core valid, then carry case
        ifc.i_sector       = 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff;
        ifc.i_sector_valid = 1'b1;
        step();
        ifc.i_sector_valid = 1'b0;
        chk("b2b_enc_data", ifc.o_enc_data, 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff);
        ifc.i_enc_data = 128'h80 << 120;
        step();
        chk("stale_valid_enable", ifc.o_enc_enable, 1);
        chk("stale_valid_tvalid", ifc.o_tweak_valid, 0);
        step();
        ifc.i_enc_valid = 1'b0;
        chk("carry_T0", ifc.o_tweak, 128'h80 << 120);
        step();
        chk("carry_T1", ifc.o_tweak, 128'h01 << 112);
        exp_t = 128'h01 << 112;
        repeat (4) begin
            step();
            exp_t = model_alpha(exp_t);
        end
        chk("pre_rst_T5", ifc.o_tweak, exp_t);

        // ---- reset mid-stream after the 5th tweak
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst_tvalid", ifc.o_tweak_valid, 0);
        chk("midrst_enable", ifc.o_enc_enable, 0);
        chk("midrst_ready", ifc.o_sector_ready, 1);
        chk("midrst_tweak", ifc.o_tweak, 0);
        @(negedge clk);
        rstn = 1'b1;
        ifc.i_tweak_ready = 1'b0;
        step();

        // ---- reduction case under backpressure, blocked request in STREAM
        ifc.i_sector       = 128'h5a;
        ifc.i_sector_valid = 1'b1;
        step();
        ifc.i_sector_valid = 1'b0;
        ifc.i_enc_data     = 128'h80;
        ifc.i_enc_valid    = 1'b1;
        step();
        step();
        ifc.i_enc_valid = 1'b0;
        chk("restart_T0", ifc.o_tweak, 128'h80);
        exp_seq[0] = 128'h80;
        for (int k = 1; k < 32; k++) exp_seq[k] = model_alpha(exp_seq[k-1]);
        j   = 0;
        cyc = 0;
        while (j < 32 && cyc < 1000) begin
            ifc.i_tweak_ready  = ($urandom_range(0, 99) < 30);
            ifc.i_sector_valid = (cyc == 3);
            ifc.i_sector       = 128'hdead_beef;
            chk("bp_valid", ifc.o_tweak_valid, 1);
            chk("bp_tweak", ifc.o_tweak, exp_seq[j]);
            chk("bp_last", ifc.o_tweak_last, (j == 31));
            if (j == 1) chk("reduce_T1", ifc.o_tweak, 128'h87 << 120);
            was_ready = ifc.i_tweak_ready;
            step();
            if (was_ready) j++;
            cyc++;
        end
        ifc.i_sector_valid = 1'b0;
        ifc.i_tweak_ready  = 1'b1;
        chk("bp_count", j, 32);
        chk("bp_done_valid", ifc.o_tweak_valid, 0);
        chk("bp_done_ready", ifc.o_sector_ready, 1);
        step();
        chk("blocked_not_queued", ifc.o_enc_enable, 0);

        // ---- single tweak per sector
        ifc1.i_sector       = 128'h1234;
        ifc1.i_sector_valid = 1'b1;
        step();
        ifc1.i_sector_valid = 1'b0;
        chk("one_enable", ifc1.o_enc_enable, 1);
        ifc1.i_enc_data  = 128'hcafe_f00d;
        ifc1.i_enc_valid = 1'b1;
        step();
        step();
        ifc1.i_enc_valid = 1'b0;
        chk("one_valid", ifc1.o_tweak_valid, 1);
        chk("one_last", ifc1.o_tweak_last, 1);
        chk("one_tweak", ifc1.o_tweak, 128'hcafe_f00d);
        ifc1.i_tweak_ready = 1'b1;
        step();
        chk("one_done_valid", ifc1.o_tweak_valid, 0);
        chk("one_done_ready", ifc1.o_sector_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
